// File: rtl/run_length_decode_stage.sv
// run_length_decode_stage: expands literal / zero-run tokens (two per cycle)
// into 64-coefficient blocks, emitted two coefficients per cycle in zig-zag
// order. Tokens are buffered in a small FIFO; a pair is only committed when
// both output slots can be filled.
module run_length_decode_stage #(
   parameter int QUANT_STAGE_WIDTH = 14,
   parameter int RUNL_STAGE_WIDTH  = 16,
   parameter int FIFO_DEPTH        = 8
) (
   input  logic                         i_clk,
   input  logic                         i_resetn,
   input  logic [RUNL_STAGE_WIDTH-1:0]  i_data0,
   input  logic [RUNL_STAGE_WIDTH-1:0]  i_data1,
   input  logic                         wen,
   output logic                         o_ready,
   output logic [QUANT_STAGE_WIDTH-1:0] o_data0,
   output logic [QUANT_STAGE_WIDTH-1:0] o_data1,
   output logic                         rsync,
   output logic                         o_last,
   output logic                         o_err
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = RUNL_STAGE_WIDTH;
   localparam int QW = QUANT_STAGE_WIDTH;

   // Progress of one slot fill: residual run, tokens taken so far, bad-N flag.
   typedef struct packed {
      logic          filled;
      logic [QW-1:0] val;
      logic [6:0]    rem;
      logic [1:0]    pops;
      logic          bad;
   } slot_t;

   logic [RW-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          keep0, keep1;
   logic [1:0]    push_cnt, pop_cnt;
   logic [RW-1:0] head0, head1;
   slot_t         slot_init, slot_a, slot_b;
   logic          emit;
   logic [5:0]    pos_q, pos_d;
   logic [6:0]    rem_q, rem_d;
   logic [QW-1:0] data0_q, data0_d, data1_q, data1_d;
   logic          rsync_q, rsync_d, last_q, last_d, err_q, err_d;
   logic          unused_tok_bits;

   function automatic logic is_pad(input logic [RW-1:0] tok);
      return !tok[RW-1] && tok[RW-2];
   endfunction

   // Fill one output slot: residual run first, then the next unconsumed token.
   function automatic slot_t fill_slot(input slot_t st, input logic [RW-1:0] tok0,
                                       input logic [RW-1:0] tok1, input logic [CW-1:0] avail);
      slot_t         r;
      logic [RW-1:0] tok;
      logic [6:0]    n;
      r        = st;
      r.filled = 1'b0;
      r.val    = '0;
      tok      = (st.pops == 2'd0) ? tok0 : tok1;
      n        = tok[6:0];
      if (st.rem != 7'd0) begin
         r.rem    = st.rem - 7'd1;
         r.filled = 1'b1;
      end else if (CW'(st.pops) < avail) begin
         r.filled = 1'b1;
         r.pops   = st.pops + 2'd1;
         if (tok[RW-1]) begin
            if (n == 7'd0 || n > 7'd64) begin
               n     = 7'd1;
               r.bad = 1'b1;
            end
            r.rem = n - 7'd1;
         end else begin
            r.val = tok[QW-1:0];
         end
      end
      return r;
   endfunction

   assign o_ready  = (count_q <= CW'(FIFO_DEPTH - 2));
   assign keep0    = wen && o_ready && !is_pad(i_data0);
   assign keep1    = wen && o_ready && !is_pad(i_data1);
   assign push_cnt = {1'b0, keep0} + {1'b0, keep1};
   assign head0    = mem_q[rd_ptr_q];
   assign head1    = mem_q[rd_ptr_q + PW'(1)];
   // Bit below the run flag carries no information for literals or runs.
   assign unused_tok_bits = ^{head0[RW-2:QW], head1[RW-2:QW]};

   // Token storage; pads never reach the FIFO, lane 1 packs behind lane 0.
   always_ff @(posedge i_clk) begin
      if (keep0) mem_q[wr_ptr_q] <= i_data0;
      if (keep1) mem_q[wr_ptr_q + PW'(keep0)] <= i_data1;
   end

   // Slot A then slot B, drawing on rem, then head, then head+1.
   always_comb begin
      slot_init     = '0;
      slot_init.rem = rem_q;
      slot_a        = fill_slot(slot_init, head0, head1, count_q);
      slot_b        = fill_slot(slot_a, head0, head1, count_q);
   end

   assign emit = slot_a.filled && slot_b.filled;

   // Commit a pair only when both slots are filled; clamp runs at block end.
   always_comb begin
      pos_d   = pos_q;
      rem_d   = rem_q;
      pop_cnt = 2'd0;
      data0_d = data0_q;
      data1_d = data1_q;
      rsync_d = 1'b0;
      last_d  = 1'b0;
      err_d   = 1'b0;
      if (emit) begin
         pos_d   = pos_q + 6'd2;
         pop_cnt = slot_b.pops;
         data0_d = slot_a.val;
         data1_d = slot_b.val;
         rsync_d = 1'b1;
         err_d   = slot_b.bad;
         rem_d   = slot_b.rem;
         if (pos_q == 6'd62) begin
            last_d = 1'b1;
            rem_d  = 7'd0;
            if (slot_b.rem != 7'd0) err_d = 1'b1;
         end
      end
   end

   // FIFO bookkeeping: push and pop in the same cycle are both honoured.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push_cnt);
      rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
      count_d  = count_q + CW'(push_cnt) - CW'(pop_cnt);
   end

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pos_q    <= '0;
         rem_q    <= '0;
         data0_q  <= '0;
         data1_q  <= '0;
         rsync_q  <= 1'b0;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         pos_q    <= pos_d;
         rem_q    <= rem_d;
         data0_q  <= data0_d;
         data1_q  <= data1_d;
         rsync_q  <= rsync_d;
         last_q   <= last_d;
         err_q    <= err_d;
      end
   end

   assign o_data0 = data0_q;
   assign o_data1 = data1_q;
   assign rsync   = rsync_q;
   assign o_last  = last_q;
   assign o_err   = err_q;
endmodule
